bpf_packet_mem: RTL

- Responder side of the BPF CPU core's packet-memory read interface.
- Ping-pong packet buffer: a writer (packet snooper) fills one buffer of 64-bit words while the CPU reads the other.
- CPU reads by byte address and gets 8 bytes starting at any byte offset, one cycle later.
- Buffers are handed over by a done/ready handshake on each side.

---
 rtl/bpf_packet_mem_if.sv | 30 +++
 rtl/bpf_packet_mem.sv | 105 ++++++++++
 2 files changed

// File: rtl/bpf_packet_mem_if.sv
// Packet-memory bus: writer fill/handoff signals plus the CPU read/handoff signals.
// master = tb/CPU+snooper side driving strobes, slave = bpf_packet_mem.
interface bpf_packet_mem_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [63:0]           wr_data;
  logic [31:0]           wr_len;
  logic                  wr_done;
  logic                  wr_ready;
  logic                  packet_mem_rd_en;
  logic [31:0]           packet_addr;
  logic [63:0]           packet_data;
  logic                  pkt_ready;
  logic [31:0]           packet_len;
  logic                  cpu_done;

  modport master (
    output wr_en, wr_addr, wr_data, wr_len, wr_done,
    output packet_mem_rd_en, packet_addr, cpu_done,
    input  wr_ready, packet_data, pkt_ready, packet_len
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_len, wr_done,
    input  packet_mem_rd_en, packet_addr, cpu_done,
    output wr_ready, packet_data, pkt_ready, packet_len
  );
endinterface

// File: rtl/bpf_packet_mem.sv
// Ping-pong packet buffer giving the BPF core 8-byte reads at any byte offset, 1-cycle read latency.
// Writer is held off by wr_ready while both buffers are FULL; reads with no packet ready return 0.
module bpf_packet_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input logic             clk,
  input logic             rst,
  bpf_packet_mem_if.slave bus
);
  localparam int HALF = 1 << (ADDR_WIDTH - 1);

  typedef enum logic {BUF_FREE = 1'b0, BUF_FULL = 1'b1} buf_state_t;

  buf_state_t  state [2];
  logic        w_sel;
  logic        r_sel;
  logic [31:0] len_q [2];
  logic [63:0] rd_data_q;

  // Index is {buffer, word >> 1}; even and odd words live in separate banks.
  logic [63:0] even_mem [2*HALF];
  logic [63:0] odd_mem  [2*HALF];

  logic        wr_ok;
  logic        rd_ok;
  logic [31:0] cur_len;

  assign wr_ok   = (state[w_sel] == BUF_FREE);
  assign rd_ok   = (state[r_sel] == BUF_FULL);
  assign cur_len = rd_ok ? len_q[r_sel] : '0;

  assign bus.wr_ready    = wr_ok;
  assign bus.pkt_ready   = rd_ok;
  assign bus.packet_len  = cur_len;
  assign bus.packet_data = rd_data_q;

  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok) begin
      if (bus.wr_addr[0])
        odd_mem[{w_sel, bus.wr_addr[ADDR_WIDTH-1:1]}] <= bus.wr_data;
      else
        even_mem[{w_sel, bus.wr_addr[ADDR_WIDTH-1:1]}] <= bus.wr_data;
    end
  end

  logic [ADDR_WIDTH-1:0] rd_w;
  logic [2:0]            rd_o;
  logic [ADDR_WIDTH-2:0] even_idx;
  logic [ADDR_WIDTH-2:0] odd_idx;
  logic [63:0]           even_rd;
  logic [63:0]           odd_rd;
  logic [63:0]           lo_word;
  logic [63:0]           hi_word;
  logic [63:0]           rd_shifted;
  logic [63:0]           rd_bytes;

  assign rd_w = bus.packet_addr[ADDR_WIDTH+2:3];
  assign rd_o = bus.packet_addr[2:0];

  // For an odd start word the following even word sits one bank row higher (wrapping at the top).
  assign odd_idx  = rd_w[ADDR_WIDTH-1:1];
  assign even_idx = rd_w[ADDR_WIDTH-1:1] + (ADDR_WIDTH-1)'(rd_w[0]);

  assign even_rd = even_mem[{r_sel, even_idx}];
  assign odd_rd  = odd_mem[{r_sel, odd_idx}];
  assign lo_word = rd_w[0] ? odd_rd  : even_rd;
  assign hi_word = rd_w[0] ? even_rd : odd_rd;

  // A shift of 64 yields zero, so offset 0 needs no special case.
  assign rd_shifted = (lo_word << {rd_o, 3'b000})
                    | (hi_word >> (7'd64 - {1'b0, rd_o, 3'b000}));

  always_comb begin
    rd_bytes = rd_shifted;
    for (int k = 0; k < 8; k++) begin
      if ({1'b0, bus.packet_addr} + 33'(k) >= {1'b0, cur_len})
        rd_bytes[63-8*k -: 8] = 8'h00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state[0]  <= BUF_FREE;
      state[1]  <= BUF_FREE;
      w_sel     <= 1'b0;
      r_sel     <= 1'b0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      rd_data_q <= '0;
    end else begin
      // Writer and CPU always own different buffers, so both handoffs can land together.
      if (bus.wr_done && wr_ok) begin
        state[w_sel] <= BUF_FULL;
        len_q[w_sel] <= bus.wr_len;
        w_sel        <= ~w_sel;
      end
      if (bus.cpu_done && rd_ok) begin
        state[r_sel] <= BUF_FREE;
        r_sel        <= ~r_sel;
      end
      if (bus.packet_mem_rd_en)
        rd_data_q <= rd_bytes;
    end
  end
endmodule
